// File: rtl/me_frame_memory.sv
// Frame memory responder for the motion-estimation engine: byte-stream loader for the
// reference block and search window, three registered read ports, and run/result sequencing.
module me_frame_memory #(
    parameter int DATA_W       = 8,
    parameter int REF_DEPTH    = 256,
    parameter int SEARCH_DEPTH = 1024,
    parameter int REF_AW       = 8,
    parameter int SEARCH_AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [DATA_W-1:0]    load_data,
    output logic                 start_signal,
    input  logic                 process_completed,
    input  logic [7:0]           best_distance,
    input  logic [3:0]           motion_vector_x,
    input  logic [3:0]           motion_vector_y,
    input  logic [REF_AW-1:0]    address_ref,
    input  logic [SEARCH_AW-1:0] address_search1,
    input  logic [SEARCH_AW-1:0] address_search2,
    output logic [DATA_W-1:0]    ref_data,
    output logic [DATA_W-1:0]    search_data1,
    output logic [DATA_W-1:0]    search_data2,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [7:0]           result_distance,
    output logic [3:0]           result_mv_x,
    output logic [3:0]           result_mv_y
);

    typedef enum logic [1:0] {
        LOAD_REF  = 2'd0,
        LOAD_SRCH = 2'd1,
        RUN       = 2'd2,
        RESULT    = 2'd3
    } state_t;

    localparam logic [SEARCH_AW-1:0] REF_LAST    = SEARCH_AW'(REF_DEPTH - 1);
    localparam logic [SEARCH_AW-1:0] SEARCH_LAST = SEARCH_AW'(SEARCH_DEPTH - 1);

    logic [DATA_W-1:0]    ref_mem    [0:REF_DEPTH-1];
    logic [DATA_W-1:0]    search_mem [0:SEARCH_DEPTH-1];

    state_t               state_r;
    logic [SEARCH_AW-1:0] wr_ptr_r;
    logic                 load_ready_r;
    logic                 start_signal_r;
    logic                 result_valid_r;
    logic [7:0]           result_distance_r;
    logic [3:0]           result_mv_x_r;
    logic [3:0]           result_mv_y_r;
    logic [DATA_W-1:0]    ref_data_r;
    logic [DATA_W-1:0]    search_data1_r;
    logic [DATA_W-1:0]    search_data2_r;

    logic                 accept_s;
    logic                 ref_we_s;
    logic                 search_we_s;

    // Load handshake decode; load_ready_r is high only in the two load states.
    always_comb begin
        accept_s    = load_valid && load_ready_r;
        ref_we_s    = 1'b0;
        search_we_s = 1'b0;
        if (accept_s && (state_r == LOAD_REF)) begin
            ref_we_s = 1'b1;
        end else if (accept_s && (state_r == LOAD_SRCH)) begin
            search_we_s = 1'b1;
        end else begin
            ref_we_s    = 1'b0;
            search_we_s = 1'b0;
        end
    end

    // Memory array writes; arrays intentionally carry no reset.
    always_ff @(posedge clk) begin
        if (ref_we_s) begin
            ref_mem[wr_ptr_r[REF_AW-1:0]] <= load_data;
        end
        if (search_we_s) begin
            search_mem[wr_ptr_r] <= load_data;
        end
    end

    // Registered read ports; nonblocking reads give read-before-write on collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_data_r     <= {DATA_W{1'b0}};
            search_data1_r <= {DATA_W{1'b0}};
            search_data2_r <= {DATA_W{1'b0}};
        end else begin
            ref_data_r     <= ref_mem[address_ref];
            search_data1_r <= search_mem[address_search1];
            search_data2_r <= search_mem[address_search2];
        end
    end

    // Frame sequencer with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= LOAD_REF;
            wr_ptr_r          <= {SEARCH_AW{1'b0}};
            load_ready_r      <= 1'b1;
            start_signal_r    <= 1'b0;
            result_valid_r    <= 1'b0;
            result_distance_r <= 8'd0;
            result_mv_x_r     <= 4'd0;
            result_mv_y_r     <= 4'd0;
        end else begin
            case (state_r)
                LOAD_REF: begin
                    if (accept_s && (wr_ptr_r == REF_LAST)) begin
                        state_r  <= LOAD_SRCH;
                        wr_ptr_r <= {SEARCH_AW{1'b0}};
                    end else if (accept_s) begin
                        wr_ptr_r <= wr_ptr_r + SEARCH_AW'(1);
                    end
                end
                LOAD_SRCH: begin
                    if (accept_s && (wr_ptr_r == SEARCH_LAST)) begin
                        state_r        <= RUN;
                        wr_ptr_r       <= {SEARCH_AW{1'b0}};
                        load_ready_r   <= 1'b0;
                        start_signal_r <= 1'b1;
                    end else if (accept_s) begin
                        wr_ptr_r <= wr_ptr_r + SEARCH_AW'(1);
                    end
                end
                RUN: begin
                    if (process_completed) begin
                        state_r           <= RESULT;
                        start_signal_r    <= 1'b0;
                        result_valid_r    <= 1'b1;
                        result_distance_r <= best_distance;
                        result_mv_x_r     <= motion_vector_x;
                        result_mv_y_r     <= motion_vector_y;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        state_r        <= LOAD_REF;
                        result_valid_r <= 1'b0;
                        load_ready_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= LOAD_REF;
                    wr_ptr_r       <= {SEARCH_AW{1'b0}};
                    load_ready_r   <= 1'b1;
                    start_signal_r <= 1'b0;
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready      = load_ready_r;
    assign start_signal    = start_signal_r;
    assign result_valid    = result_valid_r;
    assign result_distance = result_distance_r;
    assign result_mv_x     = result_mv_x_r;
    assign result_mv_y     = result_mv_y_r;
    assign ref_data        = ref_data_r;
    assign search_data1    = search_data1_r;
    assign search_data2    = search_data2_r;

endmodule

// File: tb/tb_me_frame_memory.sv
// Directed testbench for me_frame_memory: load, readback, run/result handshake,
// mid-load reset and gapped loading.
module tb_me_frame_memory;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       start_signal;
    logic       process_completed;
    logic [7:0] best_distance;
    logic [3:0] motion_vector_x;
    logic [3:0] motion_vector_y;
    logic [7:0] address_ref;
    logic [9:0] address_search1;
    logic [9:0] address_search2;
    logic [7:0] ref_data;
    logic [7:0] search_data1;
    logic [7:0] search_data2;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] result_distance;
    logic [3:0] result_mv_x;
    logic [3:0] result_mv_y;

    int checks = 0;
    int errors = 0;

    me_frame_memory dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .start_signal(start_signal), .process_completed(process_completed),
        .best_distance(best_distance), .motion_vector_x(motion_vector_x),
        .motion_vector_y(motion_vector_y),
        .address_ref(address_ref), .address_search1(address_search1),
        .address_search2(address_search2),
        .ref_data(ref_data), .search_data1(search_data1), .search_data2(search_data2),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_distance(result_distance), .result_mv_x(result_mv_x), .result_mv_y(result_mv_y)
    );

    always #5 clk = ~clk;

    // mode 0: identity; 1: partial-load filler; 2: reload; 3: gapped load
    function automatic logic [7:0] pat(input int mode, input int k);
        case (mode)
            0:       pat = 8'(k);
            1:       pat = 8'(k + 128);
            2:       pat = 8'(k * 7 + 3);
            default: pat = 8'(k * 5 + 1);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; load_data = 8'd0; process_completed = 1'b0;
        best_distance = 8'd0; motion_vector_x = 4'd0; motion_vector_y = 4'd0;
        address_ref = 8'd0; address_search1 = 10'd0; address_search2 = 10'd0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (start_signal !== 1'b0) begin errors++; $display("FAIL reset_start act=%b exp=0", start_signal); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid act=%b exp=0", result_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready act=%b exp=1", load_ready); end
        checks++; if ({ref_data, search_data1, search_data2} !== 24'd0) begin errors++;
            $display("FAIL reset_rdata act=%h exp=0", {ref_data, search_data1, search_data2}); end
        checks++; if ({result_distance, result_mv_x, result_mv_y} !== 16'd0) begin errors++;
            $display("FAIL reset_result act=%h exp=0", {result_distance, result_mv_x, result_mv_y}); end
        rst_n = 1'b1;
        // completion and result_ready outside RUN/RESULT must be ignored
        process_completed = 1'b1; best_distance = 8'h77; motion_vector_x = 4'h5; result_ready = 1'b1;
        tick();
        process_completed = 1'b0; result_ready = 1'b0;
        checks++; if (result_valid !== 1'b0 || result_distance !== 8'd0) begin errors++;
            $display("FAIL idle_completed act=%b/%h exp=0/00", result_valid, result_distance); end
        checks++; if (load_ready !== 1'b1 || start_signal !== 1'b0) begin errors++;
            $display("FAIL idle_state act=%b%b exp=10", load_ready, start_signal); end
    endtask

    task automatic test_full_load();
        for (int k = 0; k < 1280; k++) begin
            load_valid = 1'b1;
            load_data  = pat(0, k);
            tick();
            if (k == 255 || k == 1278) begin
                checks++; if (load_ready !== 1'b1 || start_signal !== 1'b0) begin errors++;
                    $display("FAIL load_mid k=%0d act=%b%b exp=10", k, load_ready, start_signal); end
            end
        end
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_done_ready act=%b exp=0", load_ready); end
        checks++; if (start_signal !== 1'b1) begin errors++; $display("FAIL load_done_start act=%b exp=1", start_signal); end
    endtask

    task automatic test_readback();
        // load attempts in RUN must not reach memory
        load_valid = 1'b1; load_data = 8'hEE;
        address_ref = 8'h35; address_search1 = 10'h2A7; address_search2 = 10'h2A7;
        tick();
        checks++; if (ref_data !== 8'h35) begin errors++; $display("FAIL rd_ref35 act=%h exp=35", ref_data); end
        checks++; if (search_data1 !== 8'hA7 || search_data2 !== 8'hA7) begin errors++;
            $display("FAIL rd_srch2a7 act=%h/%h exp=a7/a7", search_data1, search_data2); end
        address_ref = 8'h00; address_search1 = 10'h000; address_search2 = 10'h3FF;
        #1;
        checks++; if (ref_data !== 8'h35) begin errors++; $display("FAIL rd_latency act=%h exp=35", ref_data); end
        tick();
        checks++; if (ref_data !== 8'h00 || search_data1 !== 8'h00 || search_data2 !== 8'hFF) begin errors++;
            $display("FAIL rd_edges act=%h/%h/%h exp=00/00/ff", ref_data, search_data1, search_data2); end
        address_ref = 8'hFF; address_search1 = 10'h100; address_search2 = 10'h1FF;
        tick();
        checks++; if (ref_data !== 8'hFF || search_data1 !== 8'h00 || search_data2 !== 8'hFF) begin errors++;
            $display("FAIL rd_top act=%h/%h/%h exp=ff/00/ff", ref_data, search_data1, search_data2); end
        load_valid = 1'b0;
        checks++; if (start_signal !== 1'b1 || load_ready !== 1'b0) begin errors++;
            $display("FAIL run_hold act=%b%b exp=10", start_signal, load_ready); end
    endtask

    task automatic test_run_result();
        best_distance = 8'h12; motion_vector_x = 4'h3; motion_vector_y = 4'hE; process_completed = 1'b1;
        tick();
        process_completed = 1'b0;
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL res_valid act=%b exp=1", result_valid); end
        checks++; if ({result_distance, result_mv_x, result_mv_y} !== 16'h123E) begin errors++;
            $display("FAIL res_value act=%h exp=123e", {result_distance, result_mv_x, result_mv_y}); end
        checks++; if (start_signal !== 1'b0) begin errors++; $display("FAIL res_start act=%b exp=0", start_signal); end
    endtask

    task automatic test_result_hold();
        best_distance = 8'h99; motion_vector_x = 4'h1; motion_vector_y = 4'h2; process_completed = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (result_valid !== 1'b1 || {result_distance, result_mv_x, result_mv_y} !== 16'h123E) begin
                errors++; $display("FAIL hold c=%0d act=%b/%h exp=1/123e", c, result_valid,
                    {result_distance, result_mv_x, result_mv_y}); end
        end
        process_completed = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL hold_ready act=%b exp=0", load_ready); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL handoff_valid act=%b exp=0", result_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL handoff_ready act=%b exp=1", load_ready); end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 600; k++) begin
            load_valid = 1'b1; load_data = pat(1, k);
            tick();
        end
        load_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++; if (start_signal !== 1'b0 || result_valid !== 1'b0 || ref_data !== 8'd0) begin errors++;
            $display("FAIL midrst_outs act=%b%b/%h exp=00/00", start_signal, result_valid, ref_data); end
        tick();
        rst_n = 1'b1;
        address_ref = 8'h00; address_search1 = 10'd0; address_search2 = 10'd0;
        // full reload; the first byte also collides with a read of ref address 0
        for (int k = 0; k < 1280; k++) begin
            load_valid = 1'b1; load_data = pat(2, k);
            process_completed = (k == 1279);
            best_distance = 8'hA5; motion_vector_x = 4'h9; motion_vector_y = 4'h4;
            tick();
            if (k == 0) begin
                checks++; if (ref_data !== pat(1, 0)) begin errors++;
                    $display("FAIL rbw act=%h exp=%h", ref_data, pat(1, 0)); end
            end
            if (k == 1278) begin
                checks++; if (start_signal !== 1'b0 || load_ready !== 1'b1) begin errors++;
                    $display("FAIL reload_early act=%b%b exp=01", start_signal, load_ready); end
            end
        end
        load_valid = 1'b0;
        checks++; if (start_signal !== 1'b1 || result_valid !== 1'b0) begin errors++;
            $display("FAIL reload_run act=%b%b exp=10", start_signal, result_valid); end
        tick();
        process_completed = 1'b0;
        checks++; if (result_valid !== 1'b1 || {result_distance, result_mv_x, result_mv_y} !== 16'hA594) begin
            errors++; $display("FAIL first_cycle_cap act=%b/%h exp=1/a594", result_valid,
                {result_distance, result_mv_x, result_mv_y}); end
        address_ref = 8'h00; address_search1 = 10'h000; address_search2 = 10'h3FF;
        tick();
        checks++; if (ref_data !== pat(2, 0) || search_data1 !== pat(2, 256) || search_data2 !== pat(2, 1279)) begin
            errors++; $display("FAIL reload_rd act=%h/%h/%h exp=%h/%h/%h", ref_data, search_data1, search_data2,
                pat(2, 0), pat(2, 256), pat(2, 1279)); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++; if (result_valid !== 1'b0 || load_ready !== 1'b1) begin errors++;
            $display("FAIL reload_handoff act=%b%b exp=01", result_valid, load_ready); end
    endtask

    task automatic test_gapped_load();
        int cnt = 0;
        int cyc = 0;
        logic v;
        while (cnt < 1280 && cyc < 4000) begin
            v = 1'($urandom_range(0, 1));
            load_valid = v; load_data = pat(3, cnt);
            tick();
            cyc++;
            if (v) cnt++;
            checks++; if (start_signal !== (cnt == 1280)) begin errors++;
                $display("FAIL gap_start cnt=%0d act=%b exp=%b", cnt, start_signal, (cnt == 1280)); end
        end
        load_valid = 1'b0;
        checks++; if (cnt != 1280) begin errors++; $display("FAIL gap_timeout act=%0d exp=1280", cnt); end
        for (int a = 0; a < 1024; a++) begin
            address_ref = 8'(a); address_search1 = 10'(a); address_search2 = 10'(1023 - a);
            tick();
            if (a < 256) begin
                checks++; if (ref_data !== pat(3, a)) begin errors++;
                    $display("FAIL gap_ref a=%0d act=%h exp=%h", a, ref_data, pat(3, a)); end
            end
            checks++; if (search_data1 !== pat(3, 256 + a) || search_data2 !== pat(3, 1279 - a)) begin errors++;
                $display("FAIL gap_srch a=%0d act=%h/%h exp=%h/%h", a, search_data1, search_data2,
                    pat(3, 256 + a), pat(3, 1279 - a)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_readback();
        test_run_result();
        test_result_hold();
        test_mid_reset();
        test_gapped_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
